// File: rtl/cs_pkg.sv
// Shared types, constants and step functions for the CS built-in self test.
package cs_pkg;
   localparam int unsigned X_W = 8;
   localparam int unsigned Y_W = 10;
   localparam logic [7:0]  LFSR_TAPS = 8'hB8;   // s[7], s[5], s[4], s[3]
   localparam logic [15:0] MISR_POLY = 16'h1021;

   typedef enum logic [1:0] {IDLE, CSRST, RUN, DONE} state_t;

   function automatic logic [X_W-1:0] lfsr_next(input logic [X_W-1:0] s);
      return {s[X_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [Y_W-1:0] din);
      return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : '0) ^ {{(16-Y_W){1'b0}}, din};
   endfunction
endpackage

// File: rtl/cs_bist_if.sv
// Link between the BIST controller (master) and the CS block under test (slave).
interface cs_bist_if;
   logic                    cs_reset;
   logic [cs_pkg::X_W-1:0]  x_out;
   logic [cs_pkg::Y_W-1:0]  y_in;

   modport master (output cs_reset, output x_out, input y_in);
   modport slave  (input cs_reset, input x_out, output y_in);
endinterface

// File: rtl/cs_misr16.sv
// 16-bit MISR compacting the 10-bit CS output.
module cs_misr16
   import cs_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           clr,
   input  logic           en,
   input  logic [Y_W-1:0] din,
   output logic [15:0]    sig
);
   always_ff @(posedge clk) begin
      if (reset || clr)
         sig <= '0;
      else if (en)
         sig <= misr_next(sig, din);
   end
endmodule

// File: rtl/cs_bist.sv
// BIST controller: drives an LFSR pattern into CS, compacts its Y stream into a MISR.
module cs_bist
   import cs_pkg::*;
#(
   parameter int unsigned N_PAT      = 2000,
   parameter int unsigned LATENCY    = 9,
   parameter logic [7:0]  SEED       = 8'h01,
   parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   cs_bist_if.master   cs,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature
);
   localparam int unsigned CW = $clog2(N_PAT + 1);
   localparam logic [CW-1:0] S_LAST = CW'(N_PAT);
   localparam logic [CW-1:0] C_LAST = CW'(N_PAT - LATENCY);
   localparam logic [CW-1:0] LAT_C  = CW'(LATENCY);

   state_t          state, state_nx;
   logic            rst_cnt;
   logic [X_W-1:0]  lfsr;
   logic [CW-1:0]   scnt, ccnt;
   logic            launch, issue, compact, finish;

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // First sample is issued on the CSRST->RUN edge so RUN cycle k presents sample k.
   always_comb begin
      state_nx = state;
      launch   = 1'b0;
      issue    = 1'b0;
      compact  = 1'b0;
      finish   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               launch   = 1'b1;
               state_nx = CSRST;
            end
         end
         CSRST: begin
            if (rst_cnt) begin
               issue    = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            issue   = (scnt < S_LAST);
            compact = (scnt >= LAT_C);
            if (compact && (ccnt == C_LAST)) begin
               finish   = 1'b1;
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign cs.cs_reset = (state == IDLE) || (state == CSRST);
   assign busy        = (state == CSRST) || (state == RUN);

   always_ff @(posedge clk) begin
      if (reset) begin
         lfsr     <= SEED;
         cs.x_out <= '0;
         scnt     <= '0;
         ccnt     <= '0;
         rst_cnt  <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
      end else begin
         if (launch) begin
            lfsr    <= SEED;
            scnt    <= '0;
            ccnt    <= '0;
            rst_cnt <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
         end
         if (state == CSRST)
            rst_cnt <= ~rst_cnt;
         if (issue) begin
            cs.x_out <= lfsr;
            lfsr     <= lfsr_next(lfsr);
            scnt     <= scnt + 1'b1;
         end
         if (compact)
            ccnt <= ccnt + 1'b1;
         // Signature register updates on this same edge, so judge its next value.
         if (finish) begin
            done <= 1'b1;
            pass <= (misr_next(signature, cs.y_in) == GOLDEN_SIG);
         end
      end
   end

   cs_misr16 u_misr (
      .clk   (clk),
      .reset (reset),
      .clr   (launch),
      .en    (compact),
      .din   (cs.y_in),
      .sig   (signature)
   );
endmodule

// File: tb/tb_cs_bist.sv
// Self-checking bench for cs_bist: two instances (full 2000-sample run and a 10-sample run).
module tb_cs_bist;
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [9:0] y);
      logic [15:0] r;
      r = {s[14:0], 1'b0};
      if (s[15]) r = r ^ 16'h1021;
      return r ^ {6'b0, y};
   endfunction

   // Stand-in for the CS netlist: a fixed combinational map from X to Y.
   function automatic logic [9:0] stub_y(input logic [7:0] x);
      return {x[1:0], x} ^ 10'h155;
   endfunction

   function automatic logic [15:0] ref_stub_sig(input int unsigned n, input int unsigned lat,
                                                input logic [7:0] seed);
      logic [7:0]  s;
      logic [15:0] sg;
      int unsigned k;
      s  = seed;
      sg = '0;
      for (int unsigned o = 0; o < (n + 49) / 50; o++)
         for (int unsigned i = 0; i < 50; i++) begin
            k = o * 50 + i + 1;
            if (k <= n) begin
               if (k >= lat) sg = misr_step(sg, stub_y(s));
               s = lfsr_step(s);
            end
         end
      return sg;
   endfunction

   localparam logic [15:0] STUB_SIG = ref_stub_sig(2000, 9, 8'h01);

   logic clk, reset, start_a, start_b, sel;
   logic [1:0] ymode;
   logic [9:0] yr_a, yr_b;
   logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
   logic [15:0] sig_a, sig_b;

   cs_bist_if ifa ();
   cs_bist_if ifb ();

   cs_bist #(.N_PAT(2000), .LATENCY(9), .SEED(8'h01), .GOLDEN_SIG(STUB_SIG)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .cs(ifa),
      .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

   cs_bist #(.N_PAT(10), .LATENCY(9), .SEED(8'h01), .GOLDEN_SIG(16'h0000)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .cs(ifb),
      .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      yr_a <= 10'($urandom);
      yr_b <= 10'($urandom);
   end

   assign ifa.y_in = (ymode == 2'd0) ? 10'h000 : (ymode == 2'd1) ? 10'h001 :
                     (ymode == 2'd2) ? yr_a : stub_y(ifa.x_out);
   assign ifb.y_in = (ymode == 2'd0) ? 10'h000 : (ymode == 2'd1) ? 10'h001 :
                     (ymode == 2'd2) ? yr_b : stub_y(ifb.x_out);

   logic [7:0]  x_o;
   logic [9:0]  y_o;
   logic        csr_o, busy_o, done_o, pass_o;
   logic [15:0] sig_o, golden_o;
   assign x_o      = sel ? ifb.x_out : ifa.x_out;
   assign y_o      = sel ? ifb.y_in : ifa.y_in;
   assign csr_o    = sel ? ifb.cs_reset : ifa.cs_reset;
   assign busy_o   = sel ? busy_b : busy_a;
   assign done_o   = sel ? done_b : done_a;
   assign pass_o   = sel ? pass_b : pass_a;
   assign sig_o    = sel ? sig_b : sig_a;
   assign golden_o = sel ? 16'h0000 : STUB_SIG;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;
   logic [15:0] last_sig, ref_sig;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_cs_reset"}, csr_o, 1'b1);
      check({tag, "_x_out"}, x_o, 8'h00);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_done"}, done_o, 1'b0);
      check({tag, "_pass"}, pass_o, 1'b0);
      check({tag, "_sig"}, sig_o, 16'h0000);
   endtask

   // One run from the current negedge; abort_at > 0 asserts reset during that RUN cycle.
   task automatic run(input int unsigned n, input int unsigned lat, input bit mid_start,
                      input int unsigned abort_at);
      logic [7:0]  s, xlast;
      logic [15:0] sg;
      logic [39:0] first5;
      int unsigned errs, seen;
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      check("csrst1_cs_reset", csr_o, 1'b1);
      check("csrst1_busy", busy_o, 1'b1);
      check("csrst1_done", done_o, 1'b0);
      @(negedge clk);
      check("csrst2_busy", {busy_o, csr_o}, 2'b11);
      @(negedge clk);
      s = 8'h01; sg = '0; errs = 0; first5 = '0; xlast = '0;
      for (int unsigned k = 1; k <= n; k++) begin
         if (k == abort_at) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            check_reset("abort");
            seen = 0;
            repeat (20) begin
               @(negedge clk);
               if (done_o !== 1'b0 || busy_o !== 1'b0) seen++;
            end
            check("abort_quiet", seen, 0);
            return;
         end
         if (x_o !== s) errs++;
         if (busy_o !== 1'b1 || csr_o !== 1'b0 || done_o !== 1'b0) errs++;
         if (k <= 5) first5 = {first5[31:0], x_o};
         if (k >= lat) sg = misr_step(sg, y_o);
         xlast = s;
         s = lfsr_step(s);
         if (sel) start_b = (mid_start && k == 50); else start_a = (mid_start && k == 50);
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
      end
      check("run_stream_errors", errs, 0);
      check("x_first5", first5, 40'h0102040811);
      check("done_entry", {done_o, busy_o, csr_o}, 3'b100);
      check("signature", sig_o, sg);
      check("pass", pass_o, (sg == golden_o));
      check("x_hold", x_o, xlast);
      @(negedge clk);
      check("done_sticky", {done_o, sig_o}, {1'b1, sg});
      last_sig = sg;
   endtask

   initial begin
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; ymode = 2'd0; sel = 1'b0;
      repeat (3) @(negedge clk);
      sel = 1'b0; check_reset("rst_a");
      sel = 1'b1; check_reset("rst_b");
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      sel = 1'b0; check("reset_beats_start", {busy_o, csr_o}, 2'b01);
      reset = 1'b0;
      @(negedge clk);

      sel = 1'b1; ymode = 2'd1;
      run(10, 9, 1'b0, 0);
      check("small_sig", sig_o, 16'h0003);
      ymode = 2'd0;
      run(10, 9, 1'b0, 0);
      check("zero_sig_pass", {sig_o, pass_o}, {16'h0000, 1'b1});

      sel = 1'b0; ymode = 2'd3;
      run(2000, 9, 1'b0, 0);
      check("closed_loop_sig", last_sig, STUB_SIG);
      check("closed_loop_pass", pass_o, 1'b1);
      ref_sig = last_sig;
      run(2000, 9, 1'b1, 0);
      check("rerun_identical", last_sig, ref_sig);

      ymode = 2'd2;
      run(2000, 9, 1'b0, 0);

      ymode = 2'd3;
      run(2000, 9, 1'b0, 100);
      run(2000, 9, 1'b0, 0);
      check("after_abort_sig", last_sig, ref_sig);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
